// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory-port arbiter.
// States, grant encoding and the default memory latency live here.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef enum logic [1:0] {GNT_NONE, GNT_I, GNT_D} grant_t;

  localparam int DEFAULT_LAG = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the I and D requesters.
// MEM_ARB_RR_EN swaps fixed D-over-I priority for round-robin on last_grant.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  grant_t last_grant,
  output grant_t grant
);

  always_comb begin
    grant = GNT_NONE;
`ifdef MEM_ARB_RR_EN
    // A tie goes to whichever port was not served last.
    if (i_req && d_req) begin
      grant = (last_grant == GNT_D) ? GNT_I : GNT_D;
    end else if (d_req) begin
      grant = GNT_D;
    end else if (i_req) begin
      grant = GNT_I;
    end
`else
    if (d_req) begin
      grant = GNT_D;
    end else if (i_req) begin
      grant = GNT_I;
    end
`endif
  end

`ifndef MEM_ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency memory port between the I-cache and D-cache controllers.
// Optional round-robin arbitration is enabled by defining MEM_ARB_RR_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LAG    = DEFAULT_LAG,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output state_t            dbg_state
);

  // Handshake: a requester raises req with we/addr/wdata and keeps req high
  // until it sees its one-cycle ready pulse; it drops req on the edge that
  // ends that cycle. Inputs are captured on the grant edge only.

  localparam int CNT_W = (LAG < 1) ? 1 : $clog2(LAG + 1);

  state_t              state_q, state_d;
  grant_t              grant_q, grant_d, pick;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  grant_t              last_grant;

`ifdef MEM_ARB_RR_EN
  grant_t last_grant_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= GNT_I;
    end else if (state_q == IDLE && pick != GNT_NONE) begin
      last_grant_q <= pick;
    end
  end

  assign last_grant = last_grant_q;
`else
  assign last_grant = GNT_I;
`endif

  mem_arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .grant      (pick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= GNT_NONE;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (pick != GNT_NONE) begin
          state_d = BUSY;
          grant_d = pick;
          cnt_d   = '0;
          if (pick == GNT_D) begin
            mem_addr_d  = {d_addr[ADDR_W-1:2], 2'b00};
            mem_we_d    = d_we;
            mem_wdata_d = d_wdata;
          end else begin
            mem_addr_d  = {i_addr[ADDR_W-1:2], 2'b00};
            mem_we_d    = i_we;
            mem_wdata_d = i_wdata;
          end
        end
      end
      BUSY: begin
        // Memory data is valid on the final count; writes capture it too.
        if (cnt_q == CNT_W'(LAG)) begin
          state_d  = DONE;
          mem_we_d = 1'b0;
          if (grant_q == GNT_D) begin
            d_rdata_d = mem_rdata;
          end else begin
            i_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = GNT_NONE;
      end
      default: begin
        state_d = IDLE;
        grant_d = GNT_NONE;
      end
    endcase
  end

  assign i_ready   = (state_q == DONE) && (grant_q == GNT_I);
  assign d_ready   = (state_q == DONE) && (grant_q == GNT_D);
  assign busy      = (state_q != IDLE);
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized two-port run
// checked against a transaction-timeline model of the arbiter.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int LAG = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0, i_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, i_wdata = '0, d_addr = '0, d_wdata = '0;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        i_ready, d_ready, mem_we, busy;
  state_t      dbg_state;

  logic        use_fixed = 1'b0;
  logic [31:0] fixed_rd = '0;
  int          checks = 0, errors = 0, cyc = 0;
  int          i_rdy_cnt = 0, d_rdy_cnt = 0, n_done = 0;
  logic [31:0] exp_q[$];

  mem_arbiter #(.LAG(LAG), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (i_ready) i_rdy_cnt++;
    if (d_ready) d_rdy_cnt++;
  end

  // Memory model: read data is a fixed function of the word address.
  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign mem_rdata = use_fixed ? fixed_rd : rd_fn(mem_addr);

  task automatic apply_reset();
    rst_n = 1'b0;
    i_req = 0; i_we = 0; i_addr = '0; i_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Driver tasks
  task automatic set_req(input logic port_d, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wd);
    if (port_d) begin
      d_req = req; d_we = we; d_addr = addr; d_wdata = wd;
    end else begin
      i_req = req; i_we = we; i_addr = addr; i_wdata = wd;
    end
  endtask

  task automatic do_req(input logic port_d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd,
                        output int wec, output logic [31:0] addr_g,
                        output logic [31:0] wd_g, output logic we_done);
    @(posedge clk); #1;
    set_req(port_d, 1'b1, we, addr, wd);
    lat = 0; wec = 0; rd = '0; addr_g = '0; wd_g = '0; we_done = 1'bx;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (mem_we) wec++;
      if (lat == 2) begin
        addr_g = mem_addr;
        wd_g = mem_wdata;
      end
      if (port_d ? d_ready : i_ready) begin
        rd = port_d ? d_rdata : i_rdata;
        we_done = mem_we;
        break;
      end
    end
    @(posedge clk); #1;
    set_req(port_d, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic rand_driver(input logic port_d, input int n);
    int gap, w;
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        set_req(port_d, 1'b0, 1'b0, '0, '0);
        repeat (gap) @(posedge clk);
        #1;
      end
      set_req(port_d, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
      w = 0;
      forever begin
        @(negedge clk);
        if (port_d ? d_ready : i_ready) break;
        w++;
        if (w > 300) begin
          checks++; errors++;
          $display("FAIL rand_timeout port_d=%0b no ready within 300 cycles", port_d);
          break;
        end
        @(posedge clk); #1;
        // Inputs may wander while waiting; only the grant-edge values matter.
        set_req(port_d, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
      end
      @(posedge clk); #1;
    end
    set_req(port_d, 1'b0, 1'b0, '0, '0);
    n_done++;
  endtask

  // Scenario tasks
  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_addr, mem_we, mem_wdata} !== 65'h0) begin
      errors++; $display("FAIL reset_mem_port got %h/%b/%h exp 0/0/0", mem_addr, mem_we, mem_wdata);
    end
    checks++;
    if ({i_ready, d_ready, i_rdata, d_rdata} !== 66'h0) begin
      errors++; $display("FAIL reset_ports got rdy=%b%b rd=%h/%h exp 0", i_ready, d_ready, i_rdata, d_rdata);
    end
    checks++;
    if (busy !== 1'b0 || dbg_state !== IDLE) begin
      errors++; $display("FAIL reset_state got busy=%b state=%0d exp 0/IDLE", busy, dbg_state);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    int lat, wec, ic, dc;
    logic [31:0] rd, ag, wg;
    logic wed;
    ic = i_rdy_cnt; dc = d_rdy_cnt;
    do_req(1'b0, 1'b1, 32'h40, 32'h1234_5678, lat, rd, wec, ag, wg, wed);
    checks++;
    if (lat !== 7) begin errors++; $display("FAIL wr_latency got %0d exp 7", lat); end
    checks++;
    if (wec !== 5) begin errors++; $display("FAIL wr_we_cycles got %0d exp 5", wec); end
    checks++;
    if (ag !== 32'h40 || wg !== 32'h1234_5678) begin
      errors++; $display("FAIL wr_mem_port got %h/%h exp 00000040/12345678", ag, wg);
    end
    checks++;
    if (wed !== 1'b0) begin errors++; $display("FAIL wr_we_in_done got %b exp 0", wed); end
    checks++;
    if (rd !== rd_fn(32'h40)) begin errors++; $display("FAIL wr_rdata got %h exp %h", rd, rd_fn(32'h40)); end
    @(negedge clk);
    checks++;
    if (i_rdy_cnt - ic !== 1 || d_rdy_cnt - dc !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL wr_pulses got i=%0d d=%0d busy=%b exp 1/0/0", i_rdy_cnt - ic, d_rdy_cnt - dc, busy);
    end
  endtask

  task automatic test_single_read();
    int lat, wec, ic, dc;
    logic [31:0] rd, ag, wg;
    logic wed;
    use_fixed = 1'b1; fixed_rd = 32'hDEAD_BEEF;
    ic = i_rdy_cnt; dc = d_rdy_cnt;
    do_req(1'b1, 1'b0, 32'h0000_1006, 32'h0, lat, rd, wec, ag, wg, wed);
    checks++;
    if (lat !== 7) begin errors++; $display("FAIL rd_latency got %0d exp 7", lat); end
    checks++;
    if (ag !== 32'h0000_1004 || wec !== 0) begin
      errors++; $display("FAIL rd_mem_port got addr=%h we_cycles=%0d exp 00001004/0", ag, wec);
    end
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rdata got %h exp deadbeef", rd); end
    @(negedge clk);
    checks++;
    if (i_rdy_cnt - ic !== 0 || d_rdy_cnt - dc !== 1 || d_ready !== 1'b0) begin
      errors++; $display("FAIL rd_pulses got i=%0d d=%0d d_ready=%b exp 0/1/0", i_rdy_cnt - ic, d_rdy_cnt - dc, d_ready);
    end
    use_fixed = 1'b0;
  endtask

  task automatic test_simultaneous();
    int li, ld, wi, wd;
    logic [31:0] ri, rdd, ai, ad, xi, xd;
    logic ei, ed;
    int exp_li, exp_ld;
    logic [31:0] exp_first;
`ifdef MEM_ARB_RR_EN
    exp_li = 7; exp_ld = 14; exp_first = 32'h100;
`else
    exp_li = 14; exp_ld = 7; exp_first = 32'h200;
`endif
    fork
      do_req(1'b0, 1'b0, 32'h100, 32'h0, li, ri, wi, ai, xi, ei);
      do_req(1'b1, 1'b0, 32'h200, 32'h0, ld, rdd, wd, ad, xd, ed);
    join
    checks++;
    if (li !== exp_li || ld !== exp_ld) begin
      errors++; $display("FAIL sim_order got i=%0d d=%0d exp i=%0d d=%0d", li, ld, exp_li, exp_ld);
    end
    checks++;
    if (ad !== exp_first) begin errors++; $display("FAIL sim_first_addr got %h exp %h", ad, exp_first); end
    checks++;
    if (ri !== rd_fn(32'h100) || rdd !== rd_fn(32'h200)) begin
      errors++; $display("FAIL sim_rdata got %h/%h exp %h/%h", ri, rdd, rd_fn(32'h100), rd_fn(32'h200));
    end
  endtask

  task automatic test_back_to_back();
    int st, cnt, g, li, wi;
    int dt[3];
    int exp_dt[3];
    int exp_li;
    logic [31:0] ri, ai, xi;
    logic ei;
`ifdef MEM_ARB_RR_EN
    exp_dt = '{6, 20, 27}; exp_li = 14;
`else
    exp_dt = '{6, 13, 20}; exp_li = 28;
`endif
    apply_reset();
    st = 0; cnt = 0; g = 0; dt = '{0, 0, 0};
    fork
      begin
        @(posedge clk); #1;
        st = cyc;
        set_req(1'b1, 1'b1, 1'b0, 32'h300, 32'h0);
        while (cnt < 3 && g < 200) begin
          @(negedge clk); g++;
          if (d_ready) begin dt[cnt] = cyc - st; cnt++; end
        end
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
      end
      do_req(1'b0, 1'b0, 32'h104, 32'h0, li, ri, wi, ai, xi, ei);
    join
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dt[k] !== exp_dt[k]) begin
        errors++; $display("FAIL b2b_d_ready_%0d got cycle %0d exp %0d", k, dt[k], exp_dt[k]);
      end
    end
    checks++;
    if (li !== exp_li || ri !== rd_fn(32'h104)) begin
      errors++; $display("FAIL b2b_i_served got lat=%0d rd=%h exp %0d/%h", li, ri, exp_li, rd_fn(32'h104));
    end
  endtask

  task automatic test_reset_mid_busy();
    int ic, dc, lat, wec;
    logic [31:0] rd, ag, wg;
    logic wed;
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 1'b1, 32'h44, 32'hCAFE_F00D);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (mem_we !== 1'b1) begin errors++; $display("FAIL rst_pre_we got %b exp 1", mem_we); end
    ic = i_rdy_cnt; dc = d_rdy_cnt;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || dbg_state !== IDLE) begin
      errors++; $display("FAIL rst_abort got we=%b busy=%b state=%0d exp 0/0/IDLE", mem_we, busy, dbg_state);
    end
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (i_rdy_cnt !== ic || d_rdy_cnt !== dc) begin
      errors++; $display("FAIL rst_no_ready got i=%0d d=%0d exp %0d/%0d", i_rdy_cnt, d_rdy_cnt, ic, dc);
    end
    do_req(1'b1, 1'b0, 32'h80, 32'h0, lat, rd, wec, ag, wg, wed);
    checks++;
    if (lat !== 7 || rd !== rd_fn(32'h80)) begin
      errors++; $display("FAIL rst_recover got lat=%0d rd=%h exp 7/%h", lat, rd, rd_fn(32'h80));
    end
  endtask

  task automatic test_random(input int n_txn);
    logic        act, m_we, m_d, last_d, done_now, win_d;
    logic        exp_ir, exp_dr, exp_busy;
    logic [31:0] m_addr, m_wd, e_i_rd, e_d_rd, e_rd;
    int          m_edge, t, guard;
    apply_reset();
    act = 0; m_we = 0; m_d = 0; last_d = 0; m_addr = '0; m_wd = '0;
    e_i_rd = '0; e_d_rd = '0; m_edge = 0; guard = 0; n_done = 0;
    exp_q.delete();
    fork
      rand_driver(1'b0, n_txn);
      rand_driver(1'b1, n_txn);
      begin
        while (n_done < 2 && guard < 4000) begin
          @(negedge clk); guard++;
          exp_ir = 0; exp_dr = 0; exp_busy = act; done_now = 0;
          if (act) begin
            t = cyc - m_edge;
            if (t <= LAG) begin
              checks++;
              if (mem_addr !== m_addr || mem_we !== m_we || mem_wdata !== m_wd) begin
                errors++; $display("FAIL rand_mem_port cyc=%0d got %h/%b/%h exp %h/%b/%h",
                                   cyc, mem_addr, mem_we, mem_wdata, m_addr, m_we, m_wd);
              end
            end else begin
              checks++;
              if (mem_we !== 1'b0) begin errors++; $display("FAIL rand_done_we cyc=%0d got %b exp 0", cyc, mem_we); end
              e_rd = exp_q.pop_front();
              if (m_d) begin e_d_rd = e_rd; exp_dr = 1; end
              else begin e_i_rd = e_rd; exp_ir = 1; end
              act = 0; done_now = 1;
            end
          end
          checks++;
          if ({i_ready, d_ready, busy} !== {exp_ir, exp_dr, exp_busy}) begin
            errors++; $display("FAIL rand_ready_busy cyc=%0d got %b%b%b exp %b%b%b",
                               cyc, i_ready, d_ready, busy, exp_ir, exp_dr, exp_busy);
          end
          checks++;
          if (i_rdata !== e_i_rd || d_rdata !== e_d_rd) begin
            errors++; $display("FAIL rand_rdata cyc=%0d got %h/%h exp %h/%h", cyc, i_rdata, d_rdata, e_i_rd, e_d_rd);
          end
          if (!act && !done_now && (i_req || d_req)) begin
            win_d = d_req;
`ifdef MEM_ARB_RR_EN
            if (i_req && d_req) win_d = !last_d;
`endif
            act = 1; m_d = win_d; last_d = win_d; m_edge = cyc + 1;
            m_addr = (win_d ? d_addr : i_addr) & 32'hFFFF_FFFC;
            m_we   = win_d ? d_we : i_we;
            m_wd   = win_d ? d_wdata : i_wdata;
            exp_q.push_back(rd_fn(m_addr));
          end
        end
        if (guard >= 4000) begin
          checks++; errors++;
          $display("FAIL rand_monitor_timeout done=%0d exp 2", n_done);
        end
      end
    join
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_busy();
    test_random(25);
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
